// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port indices and access-size encoding.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_BYTE = 2'd2
    } size_t;

    // Byte wins when a requester raises both size strobes.
    function automatic size_t decode_size(input logic is_half, input logic is_byte);
        if (is_byte)
            return SIZE_BYTE;
        else if (is_half)
            return SIZE_HALF;
        else
            return SIZE_WORD;
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
        case (size)
            SIZE_WORD: return addr_lo != 2'b00;
            SIZE_HALF: return addr_lo[0];
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Saturating counter of cycles port 1 has waited while port 0 was granted.
module dmem_arb_starve #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int              W       = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0]    LIMIT_V = W'(LIMIT);

    logic [W-1:0] r_count;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (inc && !at_limit)
            r_count <= r_count + W'(1);
    end

    assign at_limit = (r_count == LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (MEM stage vs loader/debug) with IDLE/ACCESS/RESP sequencing.
// Define DMEM_ARB_ALIGN_CHECK_EN to suppress and flag misaligned half/word accesses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_addr,
    input  logic        req0_we,
    input  logic        req0_half,
    input  logic        req0_byte,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_addr,
    input  logic        req1_we,
    input  logic        req1_half,
    input  logic        req1_byte,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,

    output logic [31:0] mem_addr,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    output logic        mem_HalfOperation,
    output logic        mem_ByteOperation,
    output logic [31:0] mem_data_write,
    input  logic [31:0] mem_data_read
);

    state_t      r_state, w_state_next;
    logic        r_cmd_port, r_cmd_we, r_cmd_bad;
    size_t       r_cmd_size;
    logic [31:0] r_cmd_addr, r_cmd_wdata;
    logic [31:0] r_rsp0_rdata, r_rsp1_rdata;

    logic        w_at_limit, w_grant1, w_ready0, w_ready1, w_accept;
    logic        w_sel_we, w_sel_bad, w_in_access, w_in_resp;
    size_t       w_sel_size;
    logic [31:0] w_sel_addr, w_sel_wdata, w_capture;

    assign w_grant1    = req1_valid && (w_at_limit || !req0_valid);
    assign w_in_access = (r_state == ST_ACCESS);
    assign w_in_resp   = (r_state == ST_RESP);

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        if (!rst && (r_state == ST_IDLE || r_state == ST_RESP)) begin
            w_ready0 = req0_valid && !w_grant1;
            w_ready1 = w_grant1;
        end
        w_accept = w_ready0 || w_ready1;
        case (r_state)
            ST_IDLE, ST_RESP: w_state_next = w_accept ? ST_ACCESS : ST_IDLE;
            ST_ACCESS:        w_state_next = ST_RESP;
            default:          w_state_next = ST_IDLE;
        endcase
    end

    assign w_sel_addr  = w_grant1 ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant1 ? req1_wdata : req0_wdata;
    assign w_sel_we    = w_grant1 ? req1_we    : req0_we;
    assign w_sel_size  = w_grant1 ? decode_size(req1_half, req1_byte)
                                  : decode_size(req0_half, req0_byte);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign w_sel_bad   = is_misaligned(w_sel_size, w_sel_addr[1:0]);
`else
    assign w_sel_bad   = 1'b0;
`endif

    // Writes and suppressed accesses report zero read data.
    assign w_capture = (r_cmd_we || r_cmd_bad) ? 32'h0 : mem_data_read;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cmd_port   <= PORT0;
            r_cmd_we     <= 1'b0;
            r_cmd_bad    <= 1'b0;
            r_cmd_size   <= SIZE_WORD;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cmd_port  <= w_grant1 ? PORT1 : PORT0;
                r_cmd_we    <= w_sel_we;
                r_cmd_bad   <= w_sel_bad;
                r_cmd_size  <= w_sel_size;
                r_cmd_addr  <= w_sel_addr;
                r_cmd_wdata <= w_sel_wdata;
            end
            if (w_in_access) begin
                if (r_cmd_port == PORT1)
                    r_rsp1_rdata <= w_capture;
                else
                    r_rsp0_rdata <= w_capture;
            end
        end
    end

    dmem_arb_starve #(
        .LIMIT    (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_ready0 && req1_valid),
        .clr      (w_ready1 || !req1_valid),
        .at_limit (w_at_limit)
    );

    assign req0_ready        = w_ready0;
    assign req1_ready        = w_ready1;

    assign mem_addr          = r_cmd_addr;
    assign mem_data_write    = r_cmd_wdata;
    assign mem_HalfOperation = (r_cmd_size == SIZE_HALF);
    assign mem_ByteOperation = (r_cmd_size == SIZE_BYTE);
    assign mem_MemRead       = w_in_access && !r_cmd_we && !r_cmd_bad;
    assign mem_MemWrite      = w_in_access &&  r_cmd_we && !r_cmd_bad;

    assign rsp0_valid        = w_in_resp && (r_cmd_port == PORT0);
    assign rsp1_valid        = w_in_resp && (r_cmd_port == PORT1);
    assign rsp0_rdata        = r_rsp0_rdata;
    assign rsp1_rdata        = r_rsp1_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign rsp0_err          = rsp0_valid && r_cmd_bad;
    assign rsp1_err          = rsp1_valid && r_cmd_bad;
`else
    assign rsp0_err          = 1'b0;
    assign rsp1_err          = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; inputs change on the falling edge, outputs are sampled 1 ns later.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_we, req0_half, req0_byte;
    logic [31:0] req0_addr, req0_wdata;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we, req1_half, req1_byte;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic [31:0] mem_addr, mem_data_write, mem_data_read;
    logic        mem_MemWrite, mem_MemRead, mem_HalfOperation, mem_ByteOperation;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .req0_valid        (req0_valid),
        .req0_ready        (req0_ready),
        .req0_addr         (req0_addr),
        .req0_we           (req0_we),
        .req0_half         (req0_half),
        .req0_byte         (req0_byte),
        .req0_wdata        (req0_wdata),
        .rsp0_valid        (rsp0_valid),
        .rsp0_rdata        (rsp0_rdata),
        .rsp0_err          (rsp0_err),
        .req1_valid        (req1_valid),
        .req1_ready        (req1_ready),
        .req1_addr         (req1_addr),
        .req1_we           (req1_we),
        .req1_half         (req1_half),
        .req1_byte         (req1_byte),
        .req1_wdata        (req1_wdata),
        .rsp1_valid        (rsp1_valid),
        .rsp1_rdata        (rsp1_rdata),
        .rsp1_err          (rsp1_err),
        .mem_addr          (mem_addr),
        .mem_MemWrite      (mem_MemWrite),
        .mem_MemRead       (mem_MemRead),
        .mem_HalfOperation (mem_HalfOperation),
        .mem_ByteOperation (mem_ByteOperation),
        .mem_data_write    (mem_data_write),
        .mem_data_read     (mem_data_read)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive0(input logic v, input logic we, input logic h, input logic b,
                          input logic [31:0] a, input logic [31:0] d);
        req0_valid = v; req0_we = we; req0_half = h; req0_byte = b; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic h, input logic b,
                          input logic [31:0] a, input logic [31:0] d);
        req1_valid = v; req1_we = we; req1_half = h; req1_byte = b; req1_addr = a; req1_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int grants[$];
        int cyc;
        int exp_grants[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        logic [31:0] b2b_data[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

        rst = 1'b1;
        mem_data_read = 32'h0;
        drive0(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state, with port 0 already requesting.
        @(negedge clk); #1;
        check("rst_ready0",   {31'b0, req0_ready},   32'd0);
        check("rst_memread",  {31'b0, mem_MemRead},  32'd0);
        check("rst_rspvalid", {31'b0, rsp0_valid},   32'd0);
        check("rst_memaddr",  mem_addr,              32'h0);
        check("rst_rdata0",   rsp0_rdata,            32'h0);

        // Word read from port 0, accepted in the first cycle after release.
        @(negedge clk);
        rst = 1'b0;
        drive0(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("rd_accept_ready0", {31'b0, req0_ready}, 32'd1);
        check("rd_accept_ready1", {31'b0, req1_ready}, 32'd0);
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_data_read = 32'hFF00_FF00;
        #1;
        check("rd_t1_memread",  {31'b0, mem_MemRead},  32'd1);
        check("rd_t1_memwrite", {31'b0, mem_MemWrite}, 32'd0);
        check("rd_t1_addr",     mem_addr,              32'h0);
        check("rd_t1_rspvalid", {31'b0, rsp0_valid},   32'd0);
        @(negedge clk); #1;
        check("rd_t2_rspvalid", {31'b0, rsp0_valid},   32'd1);
        check("rd_t2_rdata",    rsp0_rdata,            32'hFF00_FF00);
        check("rd_t2_err",      {31'b0, rsp0_err},     32'd0);
        check("rd_t2_memread",  {31'b0, mem_MemRead},  32'd0);
        check("rd_t2_rsp1",     {31'b0, rsp1_valid},   32'd0);

        // Byte write from port 1 with both size strobes raised: must be issued as byte.
        @(negedge clk);
        mem_data_read = 32'hDEAD_0000;
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 32'h7, 32'h0000_F0F0);
        #1;
        check("wr_accept_ready1", {31'b0, req1_ready}, 32'd1);
        check("wr_accept_ready0", {31'b0, req0_ready}, 32'd0);
        @(negedge clk);
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("wr_t1_memwrite", {31'b0, mem_MemWrite},      32'd1);
        check("wr_t1_memread",  {31'b0, mem_MemRead},       32'd0);
        check("wr_t1_byte",     {31'b0, mem_ByteOperation}, 32'd1);
        check("wr_t1_half",     {31'b0, mem_HalfOperation}, 32'd0);
        check("wr_t1_addr",     mem_addr,                   32'h7);
        check("wr_t1_wdata",    mem_data_write,             32'h0000_F0F0);
        @(negedge clk); #1;
        check("wr_t2_rspvalid1", {31'b0, rsp1_valid},   32'd1);
        check("wr_t2_rdata1",    rsp1_rdata,            32'h0);
        check("wr_t2_rspvalid0", {31'b0, rsp0_valid},   32'd0);
        check("wr_t2_rdata0",    rsp0_rdata,            32'hFF00_FF00);
        check("wr_t2_memwrite",  {31'b0, mem_MemWrite}, 32'd0);
        check("wr_t2_addrhold",  mem_addr,              32'h7);

        // Contention: both ports valid every cycle; record the grant order.
        @(negedge clk);
        mem_data_read = 32'h0;
        drive0(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
        cyc = 0;
        forever begin
            #1;
            check("cont_one_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            cyc++;
            if (grants.size() >= 10 || cyc >= 60) break;
            @(negedge clk);
        end
        check("cont_accepts", grants.size(), 32'd10);
        for (int i = 0; i < 10 && i < grants.size(); i++)
            check($sformatf("cont_grant_%0d", i), grants[i], exp_grants[i]);
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk); #1;
        check("cont_last_rsp1", {31'b0, rsp1_valid}, 32'd1);

        // Back-to-back: three port-0 reads with valid held high.
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
        #1;
        check("b2b_accept_0", {31'b0, req0_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_data_read = b2b_data[k];
            if (k < 2)
                drive0(1'b1, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(4 * (k + 1)), 32'h0);
            else
                drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            check($sformatf("b2b_access_ready_%0d", k), {31'b0, req0_ready},  32'd0);
            check($sformatf("b2b_access_read_%0d", k),  {31'b0, mem_MemRead}, 32'd1);
            check($sformatf("b2b_access_addr_%0d", k),  mem_addr, 32'h100 + 32'(4 * k));
            @(negedge clk); #1;
            check($sformatf("b2b_rspvalid_%0d", k), {31'b0, rsp0_valid}, 32'd1);
            check($sformatf("b2b_rdata_%0d", k),    rsp0_rdata,          b2b_data[k]);
            check($sformatf("b2b_next_ready_%0d", k), {31'b0, req0_ready},
                  (k < 2) ? 32'd1 : 32'd0);
        end

        // Misaligned half read at 0x9.
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b1, 1'b0, 32'h9, 32'h0);
        #1;
        check("algn_accept", {31'b0, req0_ready}, 32'd1);
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_data_read = 32'hABCD_1234;
        #1;
        check("algn_half", {31'b0, mem_HalfOperation}, 32'd1);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        check("algn_memread", {31'b0, mem_MemRead}, 32'd0);
`else
        check("algn_memread", {31'b0, mem_MemRead}, 32'd1);
`endif
        @(negedge clk); #1;
        check("algn_rspvalid", {31'b0, rsp0_valid}, 32'd1);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        check("algn_err",   {31'b0, rsp0_err}, 32'd1);
        check("algn_rdata", rsp0_rdata,        32'h0);
`else
        check("algn_err",   {31'b0, rsp0_err}, 32'd0);
        check("algn_rdata", rsp0_rdata,        32'hABCD_1234);
`endif

        // Reset asserted in the middle of a write access.
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'hDEAD_BEEF);
        #1;
        check("rstmid_accept", {31'b0, req1_ready}, 32'd1);
        @(negedge clk);
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("rstmid_memwrite_before", {31'b0, mem_MemWrite}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_memwrite_async", {31'b0, mem_MemWrite}, 32'd0);
        check("rstmid_memaddr",        mem_addr,              32'h0);
        check("rstmid_wdata",          mem_data_write,        32'h0);
        check("rstmid_rdata0",         rsp0_rdata,            32'h0);
        @(negedge clk); #1;
        check("rstmid_no_rsp1", {31'b0, rsp1_valid}, 32'd0);
        check("rstmid_no_rsp0", {31'b0, rsp0_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive0(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0);
        #1;
        check("rstmid_idle_ready0",  {31'b0, req0_ready},  32'd1);
        check("rstmid_idle_memread", {31'b0, mem_MemRead}, 32'd0);
        check("rstmid_idle_rsp1",    {31'b0, rsp1_valid},  32'd0);
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("rstmid_post_access", {31'b0, mem_MemRead}, 32'd1);

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles port 1 may wait while port 0 wins before port 1 is forced to win.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 For N in {0,1}, it SHALL have the following ports. Port 0 is the pipeline MEM stage; port 1 is the loader/debug master.
- reqN_valid in 1
- reqN_ready out 1
- reqN_addr in 32 (byte address)
- reqN_we in 1
- reqN_half in 1
- reqN_byte in 1
- reqN_wdata in 32
- rspN_valid out 1
- rspN_rdata out 32
- rspN_err out 1
REQ-005 The memory side SHALL have the following ports.
- mem_addr out 32
- mem_MemWrite out 1
- mem_MemRead out 1
- mem_HalfOperation out 1
- mem_ByteOperation out 1
- mem_data_write out 32
- mem_data_read in 32 (combinational read, write on clk rising edge)

Function
REQ-006 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-007 A request SHALL be accepted in the cycle where reqN_valid and reqN_ready are both 1; its fields are latched into command registers, and the state becomes ACCESS.
REQ-008 reqN_ready SHALL be 1 only in IDLE or RESP, and only for the winning port; at most one ready SHALL be high per cycle.
REQ-009 Arbitration SHALL be fixed priority to port 0, except when the starve counter equals STARVE_LIMIT and req1_valid=1, in which case port 1 wins.
REQ-010 The starve counter SHALL:
- increment (saturating at STARVE_LIMIT) on each cycle where req1_valid=1 and port 0 is granted;
- clear when port 1 is granted or req1_valid=0.
REQ-011 In ACCESS, the mem_* outputs SHALL be driven from the command registers:
- mem_MemRead = !we;
- mem_MemWrite = we;
- mem_HalfOperation and mem_ByteOperation copied from the request.
mem_data_read SHALL be captured into the granted port's rdata register at the end of ACCESS.
REQ-012 Outside ACCESS, mem_MemRead and mem_MemWrite SHALL be 0; mem_addr, mem_data_write and the size strobes SHALL hold their last values.
REQ-013 ACCESS SHALL always last exactly one cycle and then go to RESP.
REQ-014 In RESP, the granted port's rspN_valid SHALL be 1 for exactly one cycle.
- rspN_rdata holds the read data, or 0 for writes.
- rspN_rdata holds its value until that port's next response.
REQ-015 From RESP, the next state SHALL be ACCESS if a request is accepted that cycle, otherwise IDLE. Sustained throughput is one access per 2 cycles.
REQ-016 Read latency SHALL be: accept in cycle T, mem strobe in T+1, rsp_valid in T+2.
REQ-017 If both reqN_half and reqN_byte are 1, the request SHALL be treated as byte.
REQ-018 Request inputs SHALL be ignored while the port's ready is 0; the requester holds them stable until accepted.

Reset
REQ-019 Asserting rst SHALL immediately force all of the following, even mid-ACCESS:
- state IDLE;
- all ready, rsp_valid, rsp_err, mem_MemRead and mem_MemWrite to 0;
- mem_addr, mem_data_write, the size strobes, rspN_rdata and the starve counter to 0.
REQ-020 After reset release, the first accept SHALL be possible in the first cycle.

Configuration
REQ-021 With DMEM_ARB_ALIGN_CHECK_EN defined, misaligned requests SHALL be flagged. Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]!=0. For such a request:
- ACCESS drives mem_MemRead=mem_MemWrite=0;
- RESP asserts rspN_err=1 with rspN_rdata=0.
REQ-022 Without DMEM_ARB_ALIGN_CHECK_EN, rspN_err SHALL be tied 0 and every request SHALL be issued unchanged.

Structure
REQ-023 Package dmem_arb_pkg SHALL hold the FSM state typedef, the port-index constants and the access-size encoding (WORD, HALF, BYTE).
REQ-024 The starvation counter SHALL be one sub-module, dmem_arb_starve, with inputs clk, rst, inc and clr, and output at_limit.

Verification
REQ-025 Read: port 0 reads addr 0x0 (word), with mem_data_read=0xFF00FF00 -> mem_MemRead=1 in cycle T+1; rsp0_valid=1 and rsp0_rdata=0xFF00FF00 in T+2.
REQ-026 Write: port 1 writes 0x0000F0F0 as a byte to addr 0x7 -> in T+1, mem_MemWrite=1, mem_ByteOperation=1, mem_addr=0x7; in T+2, rsp1_valid=1 and rsp1_rdata=0.
REQ-027 Contention: both ports valid continuously, STARVE_LIMIT=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1.
REQ-028 Back-to-back: port 0 issues three reads, valid held high -> accepts in cycles T, T+2, T+4; rsp0_valid in T+2, T+4, T+6.
REQ-029 Alignment, DMEM_ARB_ALIGN_CHECK_EN defined: half read at addr 0x9 -> no memory strobe; rsp0_err=1 in T+2. Macro undefined: mem_MemRead=1 and rsp0_err=0.
REQ-030 Reset in ACCESS: rst asserted mid-ACCESS during a write -> mem_MemWrite drops to 0 without waiting for a clock edge; no rsp_valid; after release, state is IDLE.
